vga_mode_scheduler: RTL



---
 rtl/vga_mode_scheduler.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_mode_scheduler.sv
// vga_mode_scheduler
//
// Control block for the 800x600 VGA pattern datapath. It turns raw user
// inputs (three buttons, a rotary encoder with push switch, a direction
// switch and a demo enable) into pattern, scale and rotation-index settings.
// New settings collect in shadow registers and reach the datapath only on a
// frame_start pulse, so a setting never changes part way through a frame.
//
// Ports
//   clk           pixel clock
//   reset         synchronous, active-high reset
//   i_btn[2:0]    raw buttons, bit0 = BTN0 (highest priority)
//   i_rot_A       raw rotary quadrature A
//   i_rot_B       raw rotary quadrature B
//   i_rot_dwn     raw rotary push
//   i_dir_sw      scale direction, 1 = grow, 0 = shrink
//   i_demo_en     auto-cycle enable (level)
//   i_frame_start one-cycle pulse at the start of vertical blanking
//   o_pattn       committed pattern, one-hot 001/010/100 or 000
//   o_pattn_scal  committed scale code, 0..SCAL_MAX
//   o_rot_indx    committed rotation index, 0..ROT_MAX
//   o_pending     shadow settings differ from the committed ones
//   o_led         {o_rot_indx, o_pending, o_pattn}

module vga_mode_scheduler #(
  parameter int DEB_MAX     = 1048574,
  parameter int DEMO_FRAMES = 120,
  parameter int SCAL_MAX    = 5,
  parameter int ROT_MAX     = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] i_btn,
  input  logic       i_rot_A,
  input  logic       i_rot_B,
  input  logic       i_rot_dwn,
  input  logic       i_dir_sw,
  input  logic       i_demo_en,
  input  logic       i_frame_start,
  output logic [2:0] o_pattn,
  output logic [2:0] o_pattn_scal,
  output logic [3:0] o_rot_indx,
  output logic       o_pending,
  output logic [7:0] o_led
);

  localparam int              DEB_W     = $clog2(DEB_MAX + 1);
  localparam logic [DEB_W-1:0] DEB_TOP  = DEB_W'(DEB_MAX);
  localparam logic [DEB_W-1:0] DEB_PRE  = DEB_W'(DEB_MAX - 1);
  localparam logic [7:0]      DEMO_LAST = 8'(DEMO_FRAMES - 1);
  localparam logic [2:0]      SCAL_TOP  = 3'(SCAL_MAX);
  localparam logic [3:0]      ROT_TOP   = 4'(ROT_MAX);

  // Synchronizer bit layout: {btn[2:0], A, B, dwn, dir, demo}.
  // A and B idle high, so their flops come out of reset at 1 to avoid a
  // phantom detent right after reset.
  localparam logic [7:0] SYNC_RST = 8'b000_11_000;

  logic [7:0] r_sync1;
  logic [7:0] r_sync2;

  logic [2:0] w_btn;
  logic       w_A;
  logic       w_B;
  logic       w_dwn;
  logic       w_dir;
  logic       w_demo;

  logic       r_deb_A;
  logic       r_deb_B;
  logic       r_deb_A_d;
  logic       r_step;

  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_press;

  logic [7:0] r_demo_cnt;
  logic [2:0] r_sh_pattn;
  logic [2:0] r_sh_scal;
  logic [3:0] r_sh_rot;
  logic [2:0] r_c_pattn;
  logic [2:0] r_c_scal;
  logic [3:0] r_c_rot;
  logic       r_pending;

  logic [7:0] w_nxt_demo_cnt;
  logic [2:0] w_nxt_sh_pattn;
  logic [2:0] w_nxt_sh_scal;
  logic [3:0] w_nxt_sh_rot;
  logic [2:0] w_nxt_c_pattn;
  logic [2:0] w_nxt_c_scal;
  logic [3:0] w_nxt_c_rot;
  logic       w_nxt_pending;

  // Two-flop synchronizer for every asynchronous user input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= SYNC_RST;
      r_sync2 <= SYNC_RST;
    end else begin
      r_sync1 <= {i_btn, i_rot_A, i_rot_B, i_rot_dwn, i_dir_sw, i_demo_en};
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn  = r_sync2[7:5];
  assign w_A    = r_sync2[4];
  assign w_B    = r_sync2[3];
  assign w_dwn  = r_sync2[2];
  assign w_dir  = r_sync2[1];
  assign w_demo = r_sync2[0];

  // Quadrature debounce: deb_A only moves when A and B agree, deb_B only
  // when they disagree, so contact bounce on one line cannot create a step.
  // A step fires one cycle after deb_A rises; deb_B then gives direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb_A   <= 1'b1;
      r_deb_B   <= 1'b1;
      r_deb_A_d <= 1'b1;
      r_step    <= 1'b0;
    end else begin
      case ({w_A, w_B})
        2'b11:   r_deb_A <= 1'b1;
        2'b00:   r_deb_A <= 1'b0;
        2'b01:   r_deb_B <= 1'b1;
        default: r_deb_B <= 1'b0;
      endcase
      r_deb_A_d <= r_deb_A;
      r_step    <= r_deb_A & ~r_deb_A_d;
    end
  end

  // Press debounce: count while held, saturate at DEB_MAX. The pulse is
  // registered from the cycle before saturation so it is high exactly on
  // the cycle the counter first reads DEB_MAX, and never again while held.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb_cnt <= '0;
      r_press   <= 1'b0;
    end else if (w_dwn) begin
      if (r_deb_cnt != DEB_TOP) begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
      r_press <= (r_deb_cnt == DEB_PRE);
    end else begin
      r_deb_cnt <= '0;
      r_press   <= 1'b0;
    end
  end

  // Next shadow and committed values. The three fields are independent,
  // so a step, a press and a pattern change in one cycle all take effect.
  // Commit copies the shadow as it stood before this edge, so an update
  // landing on a frame_start cycle waits for the following frame.
  always_comb begin
    w_nxt_sh_rot   = r_sh_rot;
    w_nxt_sh_scal  = r_sh_scal;
    w_nxt_sh_pattn = r_sh_pattn;
    w_nxt_demo_cnt = r_demo_cnt;

    if (r_step) begin
      if (r_deb_B) begin
        w_nxt_sh_rot = (r_sh_rot == 4'd0) ? ROT_TOP : r_sh_rot - 4'd1;
      end else begin
        w_nxt_sh_rot = (r_sh_rot == ROT_TOP) ? 4'd0 : r_sh_rot + 4'd1;
      end
    end

    // Scale 0 means "unset": it can only be left by growing, and
    // shrinking stops at 1.
    if (r_press) begin
      if (w_dir) begin
        if (r_sh_scal < SCAL_TOP) begin
          w_nxt_sh_scal = r_sh_scal + 3'd1;
        end
      end else if (r_sh_scal > 3'd1) begin
        w_nxt_sh_scal = r_sh_scal - 3'd1;
      end
    end

    // Buttons beat the demo step and restart the demo frame count.
    if (w_btn != 3'b000) begin
      w_nxt_demo_cnt = 8'd0;
      if (w_btn[0]) begin
        w_nxt_sh_pattn = 3'b001;
      end else if (w_btn[1]) begin
        w_nxt_sh_pattn = 3'b010;
      end else begin
        w_nxt_sh_pattn = 3'b100;
      end
    end else if (!w_demo) begin
      w_nxt_demo_cnt = 8'd0;
    end else if (i_frame_start) begin
      if (r_demo_cnt == DEMO_LAST) begin
        w_nxt_demo_cnt = 8'd0;
        case (r_sh_pattn)
          3'b001:  w_nxt_sh_pattn = 3'b010;
          3'b010:  w_nxt_sh_pattn = 3'b100;
          default: w_nxt_sh_pattn = 3'b001;
        endcase
      end else begin
        w_nxt_demo_cnt = r_demo_cnt + 8'd1;
      end
    end

    w_nxt_c_pattn = i_frame_start ? r_sh_pattn : r_c_pattn;
    w_nxt_c_scal  = i_frame_start ? r_sh_scal  : r_c_scal;
    w_nxt_c_rot   = i_frame_start ? r_sh_rot   : r_c_rot;

    w_nxt_pending = (w_nxt_sh_pattn != w_nxt_c_pattn) ||
                    (w_nxt_sh_scal  != w_nxt_c_scal)  ||
                    (w_nxt_sh_rot   != w_nxt_c_rot);
  end

  // Shadow, committed and pending registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_demo_cnt <= 8'd0;
      r_sh_pattn <= 3'd0;
      r_sh_scal  <= 3'd0;
      r_sh_rot   <= 4'd0;
      r_c_pattn  <= 3'd0;
      r_c_scal   <= 3'd0;
      r_c_rot    <= 4'd0;
      r_pending  <= 1'b0;
    end else begin
      r_demo_cnt <= w_nxt_demo_cnt;
      r_sh_pattn <= w_nxt_sh_pattn;
      r_sh_scal  <= w_nxt_sh_scal;
      r_sh_rot   <= w_nxt_sh_rot;
      r_c_pattn  <= w_nxt_c_pattn;
      r_c_scal   <= w_nxt_c_scal;
      r_c_rot    <= w_nxt_c_rot;
      r_pending  <= w_nxt_pending;
    end
  end

  assign o_pattn      = r_c_pattn;
  assign o_pattn_scal = r_c_scal;
  assign o_rot_indx   = r_c_rot;
  assign o_pending    = r_pending;
  assign o_led        = {r_c_rot, r_pending, r_c_pattn};

endmodule
